// File: rtl/spi_master_cs8_if.sv
// Bundle between the control logic, the SPI master and the slave bank.
// The master modport is the SPI master's view; slave is the other side.
interface spi_master_cs8_if #(
  parameter int NUM_SLAVES = 8,
  parameter int SEL_W      = 3
);
  logic                  start;
  logic [SEL_W-1:0]      slave_sel;
  logic [7:0]            tx_data;
  logic                  busy;
  logic                  done;
  logic [7:0]            rx_data;
  logic                  sclk;
  logic                  mosi;
  logic [NUM_SLAVES-1:0] cs_n;
  logic                  miso;

  modport master (
    input  start, slave_sel, tx_data, miso,
    output busy, done, rx_data, sclk, mosi, cs_n
  );

  modport slave (
    output start, slave_sel, tx_data, miso,
    input  busy, done, rx_data, sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_master_cs8.sv
// SPI mode-0 master, 8-bit full duplex, one active-low select per slave.
// All outputs come straight from registers.
module spi_master_cs8 #(
  parameter int CLK_DIV    = 4,
  parameter int NUM_SLAVES = 8,
  parameter int SEL_W      = 3
) (
  input  logic clk,
  input  logic rst,
  spi_master_cs8_if.master bus
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [2:0]            bits_q;
  logic [7:0]            tx_q;
  logic [7:0]            rx_sh_q;
  logic [7:0]            rx_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  sclk_q;
  logic                  mosi_q;
  logic [NUM_SLAVES-1:0] cs_n_q;
  logic [NUM_SLAVES-1:0] cs_n_d;
  logic                  cnt_last;

  assign cnt_last = (cnt_q == CW'(CLK_DIV - 1));

  // One-hot-low select for the requested slave; out-of-range selects none.
  always_comb begin
    cs_n_d = '1;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (bus.slave_sel == SEL_W'(i)) cs_n_d[i] = 1'b0;
    end
  end

  // Transfer sequencer: setup, 16 sclk half-periods, hold, then done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      tx_q    <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= '1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            tx_q    <= bus.tx_data;
            mosi_q  <= bus.tx_data[7];
            cs_n_q  <= cs_n_d;
            rx_sh_q <= '0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            bits_q  <= '0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_last) begin
            cnt_q   <= '0;
            sclk_q  <= 1'b1;
            rx_sh_q <= {rx_sh_q[6:0], bus.miso};
            state_q <= XFER;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        XFER: begin
          if (cnt_last) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
            if (sclk_q) begin
              if (bits_q == 3'd7) begin
                state_q <= HOLD;
              end else begin
                bits_q <= bits_q + 3'd1;
                tx_q   <= {tx_q[6:0], 1'b0};
                mosi_q <= tx_q[6];
              end
            end else begin
              rx_sh_q <= {rx_sh_q[6:0], bus.miso};
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        HOLD: begin
          if (cnt_last) begin
            cnt_q   <= '0;
            cs_n_q  <= '1;
            mosi_q  <= 1'b0;
            rx_q    <= rx_sh_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.cs_n    = cs_n_q;
endmodule

// File: tb/tb_spi_master_cs8.sv
// Directed bench for spi_master_cs8 at CLK_DIV=4 and CLK_DIV=1.
// A shift-out slave model answers 8'h3C on whichever slave is selected.
module tb_spi_master_cs8;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  spi_master_cs8_if #(.NUM_SLAVES(8), .SEL_W(3)) bus4 ();
  spi_master_cs8_if #(.NUM_SLAVES(8), .SEL_W(3)) bus1 ();

  spi_master_cs8 #(.CLK_DIV(4), .NUM_SLAVES(8), .SEL_W(3)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  spi_master_cs8 #(.CLK_DIV(1), .NUM_SLAVES(8), .SEL_W(3)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] sreg;
  logic [7:0] cs_prev;
  logic       sclk_prev_s;

  always @(negedge clk) begin
    if (rst) begin
      sreg        <= 8'h00;
      cs_prev     <= 8'hFF;
      sclk_prev_s <= 1'b0;
    end else begin
      if (bus4.cs_n != 8'hFF && cs_prev == 8'hFF)
        sreg <= 8'h3C;
      else if (bus4.cs_n != 8'hFF && sclk_prev_s && !bus4.sclk)
        sreg <= {sreg[6:0], 1'b0};
      cs_prev     <= bus4.cs_n;
      sclk_prev_s <= bus4.sclk;
    end
  end

  assign bus4.miso = (bus4.cs_n != 8'hFF) ? sreg[7] : 1'b0;
  assign bus1.miso = 1'b1;

  int         rises;
  int         first_rise;
  logic [7:0] mosi_bits;
  int         dones;
  int         done_at;
  logic [7:0] rx_at_done;
  logic [7:0] cs_at_done;
  int         cs_bad;
  logic       busy_c1;
  logic       busy_end;
  logic       sp;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller drives start in cycle 0; this observes cycles 1..n.
  task automatic watch4(input int n, input logic [7:0] exp_cs,
                        input int p1, input int p2);
    rises = 0; first_rise = -1; mosi_bits = 8'h00; dones = 0;
    done_at = -1; rx_at_done = 8'h00; cs_at_done = 8'h00; cs_bad = 0;
    sp = bus4.sclk;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      bus4.start = (c == p1) || (c == p2);
      if (c == 1) begin
        bus4.tx_data   = 8'h00;
        bus4.slave_sel = 3'd5;
        busy_c1        = bus4.busy;
      end
      if (c <= 68 && bus4.cs_n !== exp_cs) cs_bad++;
      if (bus4.sclk && !sp) begin
        rises++;
        if (rises == 1) first_rise = c;
        mosi_bits = {mosi_bits[6:0], bus4.mosi};
      end
      if (bus4.done) begin
        dones++;
        done_at    = c;
        rx_at_done = bus4.rx_data;
        cs_at_done = bus4.cs_n;
      end
      sp = bus4.sclk;
    end
    busy_end = bus4.busy;
  endtask

  initial begin
    int tog;
    int d1_done;
    logic [7:0] d1_mosi;
    int d1_rises;
    logic p1s;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus4.start = 1'b0; bus4.slave_sel = 3'd0; bus4.tx_data = 8'h00;
    bus1.start = 1'b0; bus1.slave_sel = 3'd0; bus1.tx_data = 8'h00;

    #3 rst = 1'b1;
    #1;
    chk("rst_cs_n",  bus4.cs_n, 8'hFF);
    chk("rst_sclk",  bus4.sclk, 1'b0);
    chk("rst_busy",  bus4.busy, 1'b0);
    chk("rst_done",  bus4.done, 1'b0);
    chk("rst_mosi",  bus4.mosi, 1'b0);
    chk("rst_rx",    bus4.rx_data, 8'h00);
    chk("rst_cs_n1", bus1.cs_n, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic transfer with ignored starts at cycles 10 and 40.
    bus4.slave_sel = 3'd3; bus4.tx_data = 8'hA5; bus4.start = 1'b1;
    watch4(72, 8'hF7, 10, 40);
    chk("basic_busy_c1", busy_c1, 1'b1);
    chk("basic_cs",      cs_bad, 0);
    chk("basic_mosi",    mosi_bits, 8'hA5);
    chk("basic_rises",   rises, 8);
    chk("basic_first",   first_rise, 5);
    chk("basic_dones",   dones, 1);
    chk("basic_done_at", done_at, 69);
    chk("basic_rx",      rx_at_done, 8'h3C);
    chk("basic_cs_done", cs_at_done, 8'hFF);
    chk("basic_busy_end", busy_end, 1'b0);
    chk("basic_rx_hold", bus4.rx_data, 8'h3C);

    // Back-to-back: start held through the done cycle.
    bus4.slave_sel = 3'd0; bus4.tx_data = 8'h5A; bus4.start = 1'b1;
    watch4(68, 8'hFE, -1, -1);
    chk("b2b_a_cs",   cs_bad, 0);
    chk("b2b_a_mosi", mosi_bits, 8'h5A);
    bus4.slave_sel = 3'd7; bus4.tx_data = 8'h01; bus4.start = 1'b1;
    @(negedge clk);
    chk("b2b_a_done", bus4.done, 1'b1);
    chk("b2b_a_csff", bus4.cs_n, 8'hFF);
    chk("b2b_a_rx",   bus4.rx_data, 8'h3C);
    watch4(70, 8'h7F, -1, -1);
    chk("b2b_b_busy", busy_c1, 1'b1);
    chk("b2b_b_cs",   cs_bad, 0);
    chk("b2b_b_last", mosi_bits[0], 1'b1);
    chk("b2b_b_mosi", mosi_bits, 8'h01);
    chk("b2b_b_done", done_at, 69);
    chk("b2b_b_rx",   rx_at_done, 8'h3C);

    // Reset abort after the third sclk rise.
    bus4.slave_sel = 3'd2; bus4.tx_data = 8'hC3; bus4.start = 1'b1;
    rises = 0;
    sp = bus4.sclk;
    for (int c = 1; c <= 40 && rises < 3; c++) begin
      @(negedge clk);
      bus4.start = 1'b0;
      if (bus4.sclk && !sp) rises++;
      sp = bus4.sclk;
    end
    chk("abort_reached", rises, 3);
    #2 rst = 1'b1;
    #1;
    chk("abort_cs",   bus4.cs_n, 8'hFF);
    chk("abort_sclk", bus4.sclk, 1'b0);
    chk("abort_busy", bus4.busy, 1'b0);
    chk("abort_rx",   bus4.rx_data, 8'h00);
    chk("abort_mosi", bus4.mosi, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (bus4.done) dones++;
    end
    chk("abort_no_done", dones, 0);
    bus4.slave_sel = 3'd1; bus4.tx_data = 8'h0F; bus4.start = 1'b1;
    watch4(70, 8'hFD, -1, -1);
    chk("post_cs",   cs_bad, 0);
    chk("post_mosi", mosi_bits, 8'h0F);
    chk("post_done", done_at, 69);
    chk("post_rx",   rx_at_done, 8'h3C);

    // CLK_DIV=1 with miso tied high.
    bus1.slave_sel = 3'd0; bus1.tx_data = 8'hFF; bus1.start = 1'b1;
    tog = 0; d1_done = -1; d1_mosi = 8'h00; d1_rises = 0;
    p1s = bus1.sclk;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      bus1.start = 1'b0;
      if (c >= 2 && c <= 17 && bus1.sclk !== p1s) tog++;
      if (bus1.sclk && !p1s) begin
        d1_rises++;
        d1_mosi = {d1_mosi[6:0], bus1.mosi};
      end
      if (bus1.done) begin
        d1_done = c;
        chk("d1_rx", bus1.rx_data, 8'hFF);
      end
      p1s = bus1.sclk;
    end
    chk("d1_toggles", tog, 16);
    chk("d1_rises",   d1_rises, 8);
    chk("d1_mosi",    d1_mosi, 8'hFF);
    chk("d1_done_at", d1_done, 18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_master_cs8.md
Name: spi_master_cs8

Overview:
- Single-clock SPI mode-0 master (CPOL=0, CPHA=0) that runs 8-bit full-duplex transfers to one of NUM_SLAVES slaves.
- Drives SCLK and MOSI, plus one active-low chip select per slave.
- Samples MISO from the slave-side MISO mux, whose output is 0 when no slave is enabled.
- Sits between the register/control logic and the slave bank; one transfer per start pulse, MSB first.

Parameters:
- CLK_DIV, 4, SCLK half-period in clk cycles; legal range >= 1.
- NUM_SLAVES, 8, number of chip-select lines.
- SEL_W, 3, slave_sel width; must equal clog2(NUM_SLAVES).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  transfer request; sampled only when busy=0.
- slave_sel  in  SEL_W  target slave index; latched on accept.
- tx_data  in  8  byte to send; latched on accept.
- busy  out  1  high from the cycle after accept until the done cycle (exclusive).
- done  out  1  one-cycle pulse at transfer end.
- rx_data  out  8  received byte; updated in the done cycle, held otherwise.
- sclk  out  1  SPI clock; idle low.
- mosi  out  1  SPI data out.
- cs_n  out  NUM_SLAVES  one-hot-low chip selects; all ones when idle.
- miso  in  1  muxed SPI data in.

Behaviour:
- All outputs are registered.
- Reset values: busy=0, done=0, rx_data=0, sclk=0, mosi=0, cs_n=all ones, FSM in IDLE, counters 0.
- Reset mid-transfer aborts immediately to these values. No done pulse is generated for the aborted transfer.
- FSM states: IDLE, SETUP, XFER, HOLD.
- IDLE: on start=1, latch tx_data, slave_sel and the internal shift register (accept = cycle 0). In cycle 1:
  - cs_n[slave_sel]=0; all other cs_n bits stay 1.
  - mosi = tx_data[7].
  - busy=1.
  - Go to SETUP.
- SETUP: hold sclk=0 for CLK_DIV cycles, then go to XFER.
- XFER: sclk toggles every CLK_DIV cycles, giving 8 rising and 8 falling edges.
  - First rise is at cycle 1+CLK_DIV. Rise k (k=0..7) is at cycle 1+(2k+1)*CLK_DIV.
  - On each rise: the rx shift register takes miso into its LSB, shifting left.
  - On each fall after rises 0..6: mosi advances to the next bit.
  - The fall after rise 7 leaves mosi unchanged and goes to HOLD (cycle 1+16*CLK_DIV).
- HOLD: sclk=0 and cs_n held for CLK_DIV cycles. Then, in one cycle (cycle 1+17*CLK_DIV):
  - cs_n returns to all ones and mosi=0.
  - rx_data is loaded from the shift register.
  - done=1 and busy=0.
  - FSM returns to IDLE.
- Back-to-back: start=1 during the done cycle is accepted, so the next transfer's cs_n falls in the following cycle. cs_n is therefore high for exactly one cycle between transfers.
- start while busy=1 is ignored; it is not queued. tx_data and slave_sel changes while busy have no effect.
- slave_sel >= NUM_SLAVES: the transfer runs with full timing, no cs_n asserted, and rx_data takes whatever miso shows (0 from the mux).
- miso needs no synchronizer: sclk is generated from clk, and slaves update on the falling edge, a full half-period before sampling.
- Total latency from accept to done: 1+17*CLK_DIV cycles.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → all outputs at their reset values immediately; cs_n=8'hFF, sclk=0.
- Basic transfer (CLK_DIV=4): slave_sel=3, tx_data=8'hA5, slave model returns 8'h3C.
  - cs_n=8'hF7 from cycle 1 to cycle 68 inclusive.
  - mosi at rises 0..7 = 1,0,1,0,0,1,0,1.
  - Exactly 8 sclk pulses, first rise at cycle 5.
  - done=1 and rx_data=8'h3C at cycle 69; cs_n=8'hFF.
- start pulses at cycles 10 and 40 of an active transfer → ignored; exactly one done, at cycle 69.
- Back-to-back: start held high through the done cycle with slave_sel=7, tx_data=8'h01.
  - Second transfer has cs_n=8'h7F starting one cycle after done.
  - Last mosi bit is 1.
- Reset abort: rst asserted after the 3rd sclk rise → cs_n=8'hFF and sclk=0 at once; no done pulse; rx_data=0; a new transfer afterwards completes normally.
- CLK_DIV=1: tx_data=8'hFF, miso tied to 1 → sclk toggles every cycle; done at cycle 18; rx_data=8'hFF.
